seg7_scan_capture: RTL

- Receive side of the multiplexed 7-segment display bus that the stopwatch drives.
- Samples the `seg7`/`line` pins and decodes each segment pattern back to a BCD digit.
- Assembles the four scanned digits into one coherent frame.
- Used as an on-board self-check and a bench monitor: it recovers the displayed time (HH:MM) without a camera or logic analyser.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_pattern_decode.sv | 33 +++
 rtl/seg7_scan_capture.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display bus.
// Segment bit order is {g,f,e,d,c,b,a}, active-high.
package seg7_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h27;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  typedef enum logic {
    S_SETTLE,
    S_HOLD
  } dwell_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational 7-segment pattern to BCD decoder.
// Unknown patterns yield DIGIT_INVALID with match low.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] digit,
  output logic       match
);

  // Exact match against the ten legal digit shapes
  always_comb begin
    digit = DIGIT_INVALID;
    match = 1'b1;
    case (pattern)
      SEG_0:   digit = 4'd0;
      SEG_1:   digit = 4'd1;
      SEG_2:   digit = 4'd2;
      SEG_3:   digit = 4'd3;
      SEG_4:   digit = 4'd4;
      SEG_5:   digit = 4'd5;
      SEG_6:   digit = 4'd6;
      SEG_7:   digit = 4'd7;
      SEG_8:   digit = 4'd8;
      SEG_9:   digit = 4'd9;
      default: begin
        digit = DIGIT_INVALID;
        match = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receive side of the multiplexed 7-segment bus: synchronises seg7/line,
// waits for each dwell to settle, decodes one digit per dwell and publishes
// a coherent four-digit frame once every digit has been seen.
// Optional: define SEG7_DP_CAPTURE_EN to capture seg7[7] as per-digit dp.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
)(
  input  logic        clk0,
  input  logic        rst,
  input  logic [7:0]  seg7,
  input  logic [3:0]  line,
  output logic [15:0] digits,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        frame_stb,
  output logic        err_pattern,
  output logic        err_line
);

  localparam int unsigned SW = $clog2(SETTLE_CYCLES);
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_SAT     = TW'(TIMEOUT_CYCLES);

  logic [7:0]  seg_in;
  logic [7:0]  seg_s1, seg_s2;
  logic [3:0]  line_s1, line_s2;
  logic [11:0] cur, prev;
  logic        changed;

  logic [SW-1:0] settle_cnt;
  logic          settle_done;

  dwell_state_t state, state_next;
  logic         fire;

  logic [IW-1:0] line_idx;
  logic          line_one, line_multi;
  logic [3:0]    dec_digit;
  logic          dec_match;

  logic [NUM_DIGITS-1:0][3:0] shadow;
  logic [NUM_DIGITS-1:0]      seen, seen_next;
  logic [TW-1:0]              to_cnt;
  logic                       complete, timeout_hit;

`ifdef SEG7_DP_CAPTURE_EN
  logic [NUM_DIGITS-1:0] shadow_dp, dp_q;
  assign seg_in = seg7;
  assign dp     = dp_q;
`else
  // dp pin is masked before the synchronizer so it cannot start a new dwell
  logic unused_dp_pin;
  assign unused_dp_pin = seg7[7];
  assign seg_in        = {1'b0, seg7[6:0]};
  assign dp            = '0;
`endif

  // Two-flop synchronizers for the display pins
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      seg_s1  <= '0;
      seg_s2  <= '0;
      line_s1 <= '0;
      line_s2 <= '0;
    end else begin
      seg_s1  <= seg_in;
      seg_s2  <= seg_s1;
      line_s1 <= line;
      line_s2 <= line_s1;
    end
  end

  assign cur     = {seg_s2, line_s2};
  assign changed = (cur != prev);

  // Previous-cycle copy of the bus and saturating stability counter
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      prev       <= '0;
      settle_cnt <= '0;
    end else begin
      prev <= cur;
      if (changed)
        settle_cnt <= '0;
      else if (settle_cnt != SETTLE_MAX)
        settle_cnt <= settle_cnt + 1'b1;
    end
  end

  assign settle_done = (settle_cnt == SETTLE_MAX);

  // Dwell FSM state register
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) state <= S_SETTLE;
    else     state <= state_next;
  end

  // Dwell FSM next state: one capture per stable dwell
  always_comb begin
    state_next = state;
    case (state)
      S_SETTLE: if (settle_done && !changed) state_next = S_HOLD;
      S_HOLD:   if (changed)                 state_next = S_SETTLE;
      default:  state_next = S_SETTLE;
    endcase
  end

  // Dwell FSM output: capture strobe; a change on the final count restarts the dwell
  always_comb begin
    fire = (state == S_SETTLE) && settle_done && !changed;
  end

  // Classify the digit-select lines and locate the active digit
  always_comb begin
    line_idx = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (line_s2[i]) line_idx = IW'(i);
    end
    line_one   = ($countones(line_s2) == 1);
    line_multi = ($countones(line_s2) > 1);
  end

  seg7_pattern_decode u_decode (
    .pattern (seg_s2[6:0]),
    .digit   (dec_digit),
    .match   (dec_match)
  );

  assign complete    = (seen == '1);
  assign timeout_hit = (to_cnt == TO_LAST);

  // Seen mask: cleared by completion or timeout, then the current capture is merged in
  always_comb begin
    seen_next = seen;
    if (complete || timeout_hit) seen_next = '0;
    if (fire && line_one) seen_next[line_idx] = 1'b1;
  end

  // Shadow capture, frame publication, timeout and error pulses
  always_ff @(posedge clk0 or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      seen        <= '0;
      to_cnt      <= '0;
      digits      <= '0;
      frame_valid <= 1'b0;
      frame_stb   <= 1'b0;
      err_pattern <= 1'b0;
      err_line    <= 1'b0;
`ifdef SEG7_DP_CAPTURE_EN
      shadow_dp   <= '0;
      dp_q        <= '0;
`endif
    end else begin
      frame_stb   <= 1'b0;
      err_pattern <= 1'b0;
      err_line    <= 1'b0;
      seen        <= seen_next;

      if (fire && line_multi) err_line <= 1'b1;

      if (fire && line_one) begin
        shadow[line_idx] <= dec_digit;
        err_pattern      <= !dec_match;
`ifdef SEG7_DP_CAPTURE_EN
        shadow_dp[line_idx] <= seg_s2[7];
`endif
      end

      if (complete) begin
        digits      <= shadow;
        frame_stb   <= 1'b1;
        frame_valid <= 1'b1;
        to_cnt      <= '0;
`ifdef SEG7_DP_CAPTURE_EN
        dp_q        <= shadow_dp;
`endif
      end else begin
        // Counter parks one past the trip point so the timeout fires only once
        if (to_cnt != TO_SAT) to_cnt <= to_cnt + 1'b1;
        if (timeout_hit) frame_valid <= 1'b0;
      end
    end
  end

endmodule
